// File: rtl/frodo_inst_sequencer.sv
// Replays a host-loaded program into the Frodo core, one word per completion handshake.
// Issue-to-issue >= 2 cycles; a per-instruction watchdog aborts a stalled run with err.
module frodo_inst_sequencer #(
    parameter int INST_WIDTH = 27,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 100000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     prog_wr_en,
    input  logic [INST_WIDTH-1:0]    prog_wr_data,
    input  logic                     prog_clear,
    output logic [$clog2(DEPTH):0]   prog_count,
    output logic                     prog_full,
    input  logic                     start,
    output logic [INST_WIDTH-1:0]    inst,
    output logic                     inst_valid,
    input  logic                     core_done,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  err_q, err_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  wr_acc;
    logic                  full;

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        inst_d     = inst_q;
        wr_acc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prog_clear) begin
                    count_d = '0;
                end else if (prog_wr_en && !full) begin
                    wr_acc  = 1'b1;
                    count_d = count_q + 1'b1;
                end
                // The run sees the count after any same-cycle load or clear.
                if (start) begin
                    err_d      = 1'b0;
                    rd_ptr_d   = '0;
                    wait_cnt_d = '0;
                    state_d    = (count_d == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                inst_d  = mem_q[rd_ptr_q];
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (core_done) begin
                    if ({1'b0, rd_ptr_q} == count_q - 1'b1) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        wait_cnt_d = '0;
                        state_d    = S_ISSUE;
                    end
                end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            inst_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            inst_q     <= inst_d;
        end
    end

    // Program storage needs no reset; prog_count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[count_q[AW-1:0]] <= prog_wr_data;
        end
    end

    assign prog_count = count_q;
    assign prog_full  = full;
    assign inst_valid = (state_q == S_ISSUE);
    assign inst       = (state_q == S_ISSUE) ? mem_q[rd_ptr_q] : inst_q;
    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
endmodule

// File: tb/tb_frodo_inst_sequencer.sv
// Randomized directed bench for frodo_inst_sequencer with a queue-based program model.
module tb_frodo_inst_sequencer;
    localparam int IW    = 27;
    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic          clk = 1'b0;
    logic          rstn;
    logic          prog_wr_en;
    logic [IW-1:0] prog_wr_data;
    logic          prog_clear;
    logic [4:0]    prog_count;
    logic          prog_full;
    logic          start;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          core_done;
    logic          busy;
    logic          done;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [IW-1:0] prog_q[$];

    frodo_inst_sequencer #(.INST_WIDTH(IW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .prog_wr_en(prog_wr_en), .prog_wr_data(prog_wr_data),
        .prog_clear(prog_clear), .prog_count(prog_count), .prog_full(prog_full),
        .start(start), .inst(inst), .inst_valid(inst_valid), .core_done(core_done),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [IW-1:0] w);
        prog_wr_en   = 1'b1;
        prog_wr_data = w;
        tick();
        prog_wr_en   = 1'b0;
        if (prog_q.size() < DEPTH) prog_q.push_back(w);
        chk("load_count", 32'(prog_count), 32'(prog_q.size()));
        chk("load_full", 32'(prog_full), 32'(prog_q.size() == DEPTH));
    endtask

    task automatic clear_prog();
        prog_clear = 1'b1;
        tick();
        prog_clear = 1'b0;
        prog_q.delete();
        chk("clear_count", 32'(prog_count), 32'd0);
    endtask

    // lat < 0 picks a random core latency (in WAIT cycles) per instruction.
    task automatic run(input bit do_start, input int lat_sel, input bit noise);
        int n;
        int lat;
        n = prog_q.size();
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (n == 0) begin
            chk("empty_done", 32'(done), 32'd1);
            chk("empty_valid", 32'(inst_valid), 32'd0);
            chk("empty_busy", 32'(busy), 32'd0);
            tick();
            chk("empty_done_end", 32'(done), 32'd0);
            chk("empty_busy_end", 32'(busy), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            chk("issue_valid", 32'(inst_valid), 32'd1);
            chk("issue_inst", 32'(inst), 32'(prog_q[i]));
            chk("issue_busy", 32'(busy), 32'd1);
            chk("issue_err", 32'(err), 32'd0);
            if (noise && i == 0) begin
                core_done    = 1'b1;
                start        = 1'b1;
                prog_wr_en   = 1'b1;
                prog_wr_data = IW'($urandom);
                prog_clear   = 1'b1;
            end
            lat = (lat_sel >= 0) ? lat_sel : int'($urandom_range(0, 3));
            tick();
            core_done  = 1'b0;
            start      = 1'b0;
            prog_wr_en = 1'b0;
            prog_clear = 1'b0;
            if (noise && i == 0) begin
                chk("noise_count", 32'(prog_count), 32'(n));
                chk("noise_busy", 32'(busy), 32'd1);
            end
            for (int w = 0; w < lat; w++) begin
                chk("wait_valid", 32'(inst_valid), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
                chk("wait_hold", 32'(inst), 32'(prog_q[i]));
                tick();
            end
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
        end
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(inst_valid), 32'd0);
        chk("end_err", 32'(err), 32'd0);
        chk("end_count", 32'(prog_count), 32'(n));
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_inst_hold", 32'(inst), 32'(prog_q[n-1]));
    endtask

    initial begin
        rstn = 1'b0; prog_wr_en = 1'b0; prog_wr_data = '0; prog_clear = 1'b0;
        start = 1'b0; core_done = 1'b0;
        #12;
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(prog_count), 32'd0);
        chk("rst_full", 32'(prog_full), 32'd0);
        rstn = 1'b1;
        tick();

        // Basic three-word program, core responds in the first WAIT cycle.
        load(27'h1000001);
        load(27'h2000002);
        load(27'h3000003);
        run(1'b1, 0, 1'b0);

        // Rerun of the same program with random latencies.
        run(1'b1, -1, 1'b0);

        // Overfill: last two writes dropped.
        clear_prog();
        for (int i = 0; i < DEPTH + 2; i++) load(IW'($urandom));
        chk("full_count", 32'(prog_count), 32'(DEPTH));
        run(1'b1, -1, 1'b0);

        // Empty program.
        clear_prog();
        run(1'b1, 0, 1'b0);

        // Write and start in the same cycle: run uses the new word.
        prog_wr_en   = 1'b1;
        prog_wr_data = IW'($urandom);
        start        = 1'b1;
        prog_q.push_back(prog_wr_data);
        tick();
        prog_wr_en = 1'b0;
        start      = 1'b0;
        run(1'b0, -1, 1'b0);

        // Watchdog abort with two words loaded.
        clear_prog();
        load(IW'($urandom));
        load(IW'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_issue", 32'(inst_valid), 32'd1);
        chk("tmo_inst", 32'(inst), 32'(prog_q[0]));
        for (int i = 0; i < TMO; i++) begin
            tick();
            chk("tmo_wait_done", 32'(done), 32'd0);
            chk("tmo_wait_err", 32'(err), 32'd0);
            chk("tmo_wait_valid", 32'(inst_valid), 32'd0);
        end
        tick();
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick();
        chk("tmo_err_sticky", 32'(err), 32'd1);
        chk("tmo_done_end", 32'(done), 32'd0);

        // Rerun clears err; core_done exactly on the timeout boundary counts as completion.
        run(1'b1, TMO - 1, 1'b0);

        // Inputs during a run are ignored, including core_done in ISSUE.
        clear_prog();
        for (int i = 0; i < 3; i++) load(IW'($urandom));
        run(1'b1, -1, 1'b1);

        // Reset in the middle of WAIT.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_count", 32'(prog_count), 32'd0);
        #2;
        rstn = 1'b1;
        prog_q.delete();
        tick();
        for (int i = 0; i < 4; i++) load(IW'($urandom));
        run(1'b1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
